arq_cmd_out_pio: RTL and testbench

// - Avalon-MM slave that sends 32-bit command words from the Nios processor to FPGA fabric logic (robot/game control).
// - It is the write-direction counterpart of the 32-bit read-only input PIO.
// - Processor writes are buffered in a FIFO and drained to the fabric through a valid/ready stream.
// - Status and control registers let software see occupancy and overflow, and flush the FIFO.

---
 rtl/arq_pio_pkg.sv | 20 ++
 rtl/arq_cmd_fifo.sv | 76 +++++++
 rtl/arq_cmd_out_pio.sv | 109 ++++++++++
 tb/tb_arq_cmd_out_pio.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/arq_pio_pkg.sv
// Shared constants for the command-output PIO: Avalon word addresses,
// STATUS bit positions and CTRL bit positions.
package arq_pio_pkg;

    // Avalon word addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_SHADOW = 2'd3;

    // STATUS register bit indices (count occupies the low CNT_W bits)
    localparam int unsigned ST_EMPTY = 16;
    localparam int unsigned ST_FULL  = 17;
    localparam int unsigned ST_OVF   = 18;

    // CTRL register bit indices
    localparam int unsigned CTL_FLUSH  = 0;
    localparam int unsigned CTL_CLROVF = 1;

endpackage

// File: rtl/arq_cmd_fifo.sv
// Synchronous command FIFO built from plain registers.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_push, i_data    write request and word
//   i_pop             head consumed this cycle (ignored when empty)
//   i_flush           empty the FIFO; wins over a same-cycle pop
//   o_data            word at the read pointer
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
//   o_drop            push refused because the FIFO is full with no pop
module arq_cmd_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop
);

    localparam int unsigned PtrW = CNT_W - 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_pop;
    logic w_accept;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_accept = i_push && (!o_full || w_pop);
    assign o_drop   = i_push && !w_accept;
    assign o_data   = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/arq_cmd_out_pio.sv
// Avalon-MM slave that queues 32-bit command words from the processor and
// streams them to fabric logic over a valid/ready interface.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   address, chipselect, write, read   Avalon slave control
//   writedata / readdata               Avalon data (readdata registered, 1-cycle latency)
//   out_data, out_valid, out_ready     command stream to the fabric
module arq_cmd_out_pio
    import arq_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] r_readdata;
    logic [DATA_W-1:0] r_shadow;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_mux;

    assign w_push    = chipselect && write && (address == ADDR_DATA);
    assign w_ctrl_wr = chipselect && write && (address == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr && writedata[CTL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr && (writedata[CTL_FLUSH] || writedata[CTL_CLROVF]);
    // Valid comes from registered occupancy only, so ready never reaches it.
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign readdata  = r_readdata;

    arq_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (writedata),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (out_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_status                = '0;
        w_status[CNT_W-1:0]     = w_count;
        w_status[ST_EMPTY]      = w_empty;
        w_status[ST_FULL]       = w_full;
        w_status[ST_OVF]        = r_overflow;
    end

    always_comb begin
        w_rd_mux = '0;
        unique case (address)
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_SHADOW: w_rd_mux = r_shadow;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_shadow   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (chipselect && read) begin
                r_readdata <= w_rd_mux;
            end
            // Shadow records every DATA write, including dropped ones.
            if (w_push) begin
                r_shadow <= writedata;
            end
            if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arq_cmd_out_pio.sv
// Directed self-checking bench for arq_cmd_out_pio.
module tb_arq_cmd_out_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    arq_cmd_out_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle Avalon write; returns at the following negedge.
    task automatic av_write(input logic [1:0] a, input logic [31:0] d, input logic cs = 1'b1);
        @(negedge clk);
        address = a; writedata = d; chipselect = cs; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // Single-cycle Avalon read and compare of registered readdata.
    task automatic av_read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        writedata = '0; out_ready = 1'b0;
        #12;
        check("rst_readdata", readdata, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_data", out_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        av_read_chk("status_reset", 2'd1, 32'h0001_0000);
        check("valid_idle", {31'b0, out_valid}, 32'h0);

        // Single write, stream visible the cycle after
        @(negedge clk);
        address = 2'd0; writedata = 32'hDEAD_BEEF; chipselect = 1'b1; write = 1'b1;
        check("valid_before_edge", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        check("valid_after_wr", {31'b0, out_valid}, 32'h1);
        check("data_after_wr", out_data, 32'hDEAD_BEEF);
        av_read_chk("status_one", 2'd1, 32'h0000_0001);
        av_read_chk("shadow_beef", 2'd3, 32'hDEAD_BEEF);
        av_read_chk("read_data_zero", 2'd0, 32'h0);
        av_read_chk("read_ctrl_zero", 2'd2, 32'h0);
        // readdata holds without a read access
        @(negedge clk);
        check("readdata_hold", readdata, 32'h0);

        // Write with chipselect low is ignored
        av_write(2'd0, 32'h1234_5678, 1'b0);
        av_read_chk("cs_low_ignored", 2'd1, 32'h0000_0001);

        // Drain the single word
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drained_one", {31'b0, out_valid}, 32'h0);

        // Fill 1..8, overflow with 9
        for (int i = 1; i <= 9; i++) av_write(2'd0, 32'(i));
        av_read_chk("status_full_ovf", 2'd1, 32'h0006_0008);
        av_read_chk("shadow_nine", 2'd3, 32'h0000_0009);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("drain_data_%0d", i), out_data, 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("drain_done", {31'b0, out_valid}, 32'h0);
        av_read_chk("ovf_sticky", 2'd1, 32'h0005_0000);
        av_write(2'd2, 32'h2);
        av_read_chk("ovf_cleared", 2'd1, 32'h0001_0000);

        // Full FIFO: write plus pop in the same cycle is accepted
        for (int i = 0; i < 8; i++) av_write(2'd0, 32'h10 + 32'(i));
        @(negedge clk);
        address = 2'd0; writedata = 32'hA5; chipselect = 1'b1; write = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; out_ready = 1'b0;
        av_read_chk("full_push_pop", 2'd1, 32'h0002_0008);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("fp_data_%0d", i), out_data, 32'h10 + 32'(i));
            @(negedge clk);
        end
        check("fp_last_a5", out_data, 32'hA5);
        @(negedge clk);
        out_ready = 1'b0;
        check("fp_empty", {31'b0, out_valid}, 32'h0);

        // Overflow then CLROVF keeps contents, FLUSH empties
        for (int i = 0; i < 9; i++) av_write(2'd0, 32'h20 + 32'(i));
        av_read_chk("ovf_again", 2'd1, 32'h0006_0008);
        av_write(2'd2, 32'h2);
        av_read_chk("clrovf_keeps", 2'd1, 32'h0002_0008);
        av_write(2'd0, 32'h99);
        av_read_chk("ovf_set2", 2'd1, 32'h0006_0008);
        av_write(2'd2, 32'h1);
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        av_read_chk("flush_status", 2'd1, 32'h0001_0000);

        // Push 3 then flush; pointers restart at 0
        for (int i = 0; i < 3; i++) av_write(2'd0, 32'h30 + 32'(i));
        av_read_chk("three", 2'd1, 32'h0000_0003);
        av_write(2'd2, 32'h1);
        check("flush3_valid", {31'b0, out_valid}, 32'h0);
        av_read_chk("flush3_status", 2'd1, 32'h0001_0000);
        av_write(2'd0, 32'h77);
        check("post_flush_data", out_data, 32'h77);
        av_write(2'd2, 32'h1);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 5; i++) av_write(2'd0, 32'h50 + 32'(i));
        av_read_chk("five", 2'd1, 32'h0000_0005);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'h0);
        check("async_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        av_read_chk("after_reset", 2'd1, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
